// File: rtl/dmux8way_reg.sv
// Registered 1-to-8 demultiplexer with per-lane one-hot valid flags.
// One register stage; idle or unselected lanes read zero.
module dmux8way_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] entrada,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [7:0]       out_valid
);

  logic [WIDTH-1:0] r_lane [8];
  logic [7:0]       r_valid;
  logic [7:0]       w_hit;

  always_comb begin
    w_hit = 8'h00;
    if (in_valid) w_hit = 8'h01 << sel;
  end

  // Every lane is rewritten each cycle, so stale data never lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++)
        r_lane[k] <= '0;
      r_valid <= 8'h00;
    end else begin
      for (int k = 0; k < 8; k++)
        r_lane[k] <= w_hit[k] ? entrada : '0;
      r_valid <= w_hit;
    end
  end

  assign o0 = r_lane[0];
  assign o1 = r_lane[1];
  assign o2 = r_lane[2];
  assign o3 = r_lane[3];
  assign o4 = r_lane[4];
  assign o5 = r_lane[5];
  assign o6 = r_lane[6];
  assign o7 = r_lane[7];
  assign out_valid = r_valid;

endmodule

// File: tb/tb_dmux8way_reg.sv
// Bench for dmux8way_reg: directed scenarios plus random traffic
// checked against a lane-array reference model.
module tb_dmux8way_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] entrada = '0;
  logic [2:0]   sel = '0;
  logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]   out_valid;

  logic [W-1:0] obs [8];
  logic [W-1:0] exp_o [8];
  logic [7:0]   exp_v;
  int           n_pass = 0;
  int           n_total = 0;

  assign obs[0] = o0;
  assign obs[1] = o1;
  assign obs[2] = o2;
  assign obs[3] = o3;
  assign obs[4] = o4;
  assign obs[5] = o5;
  assign obs[6] = o6;
  assign obs[7] = o7;

  always #5 clk = ~clk;

  dmux8way_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .entrada(entrada), .sel(sel),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s.o%0d", tag, k), 32'(obs[k]), 32'(exp_o[k]));
    chk($sformatf("%s.valid", tag), 32'(out_valid), 32'(exp_v));
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) exp_o[k] = '0;
    exp_v = 8'h00;
  endtask

  // Model: a transfer of d to lane s leaves exactly that lane non-zero-capable.
  task automatic model_xfer(input logic v, input int s, input logic [W-1:0] d);
    model_clear();
    if (v) begin
      exp_o[s] = d;
      exp_v = 8'(1 << s);
    end
  endtask

  task automatic step(input string tag, input logic v, input int s,
                      input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    sel = 3'(s);
    entrada = d;
    @(posedge clk);
    #1;
    model_xfer(v, s, d);
    chk_all(tag);
  endtask

  initial begin
    model_clear();
    #12;
    chk_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-cycle while o3 holds data
    step("pre_rst", 1'b1, 3, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_all("async_rst");
    // Transfer coincident with reset is discarded
    @(negedge clk);
    in_valid = 1'b1; sel = 3'd4; entrada = 4'h9;
    @(posedge clk);
    #1;
    chk_all("rst_discard");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    for (int s = 0; s < 8; s++)
      step($sformatf("sweep%0d", s), 1'b1, s, 4'b0001);

    step("pat_a", 1'b1, 5, 4'hA);
    step("pat_5", 1'b1, 5, 4'h5);

    step("idle_pre", 1'b1, 2, 4'hF);
    step("idle", 1'b0, 2, 4'hF);

    step("zero7", 1'b1, 7, 4'h0);

    step("b2b_1", 1'b1, 1, 4'hF);
    step("b2b_6", 1'b1, 6, 4'h3);
    step("b2b_1c", 1'b1, 1, 4'hC);

    for (int i = 0; i < 200; i++)
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), W'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
